data_memory_bytewise: RTL
=========================

# data_memory_bytewise

Parametrised byte-addressable data memory for the single-cycle/pipelined core's load/store path, replacing the word-only data memory. It supports RV32 sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte enables and sign/zero extension. After reset it runs a one-word-per-cycle clearing sequence. Requests use a valid/ready handshake, and each accepted request gets exactly one registered response.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words. Must be a power of two, ≥ 2.
- ADDR_WIDTH, 32: width of the byte address.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_funct3  in  3  RV32 size/sign code
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result after extension; 0 for stores and errors
- rsp_error  out  1  request rejected: misaligned, out of range, or illegal funct3
- init_done  out  1  clearing sequence finished

## Operation
- FSM states: CLEAR and READY.
  - Reset forces CLEAR and sets clr_idx = 0.
  - In CLEAR, word clr_idx is written to 0 each cycle.
  - When clr_idx == DEPTH-1 the FSM moves to READY on that edge.
  - READY is held until the next reset.
- req_ready = 1 only in READY. init_done = (state == READY).
- A request is accepted on a cycle where req_valid && req_ready.
- Word index = req_addr[log2(DEPTH)+1:2]. Byte lane = req_addr[1:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Error conditions, any of which sets rsp_error:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - req_addr ≥ 4·DEPTH.
  - Illegal funct3.
- On error: no memory write, rsp_error = 1, rsp_rdata = 0.
- Store:
  - Byte enables: SB → 1 lane; SH → lanes {a, a+1}; SW → all 4 lanes.
  - req_wdata low bytes are steered into the selected lanes.
  - Unselected lanes keep their old value.
- Load:
  - The selected bytes are shifted down to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Every accepted request produces exactly one response: rsp_valid = 1 on the following cycle.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, init_done = 0.
  - Memory contents are undefined until CLEAR completes.
- Clear duration is DEPTH cycles. The first request can be accepted DEPTH cycles after reset deasserts.
- Store commits on the accepting edge. Load data is registered. Response latency is 1 cycle for both.
- Throughput is one request per cycle. Back-to-back requests give back-to-back rsp_valid pulses.
- Read-after-write: a load accepted the cycle after a store to the same word returns the newly written bytes.
- rsp_valid is a single-cycle pulse. It is 0 in any cycle following a non-accepting cycle.
- Reset asserted mid-operation:
  - The pending response is dropped; rsp_valid = 0 on the next cycle.
  - The clear sequence restarts from index 0.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until it is accepted.

## Structure
- Package dmem_pkg holds:
  - funct3 constants as an enum: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state enum {CLEAR, READY}.
  - Function is_legal(write, funct3).
- Sub-module dmem_lane_align (combinational) computes:
  - Store path: byte enables and steered write data from funct3/addr[1:0].
  - Load path: extraction and sign/zero extension.
  - Misalignment flag.
- The top level holds the memory array, FSM, clear counter and response registers.

## Test plan
- Reset, then poll init_done.
  - init_done rises exactly DEPTH cycles after reset deasserts (64 at defaults).
  - A LW to any address then returns 0x00000000.
- SW 0x8899AABB @0x10; SB 0x11 @0x11; load back @0x10.
  - LW @0x10 returns 0x889911BB.
  - LB @0x13 returns 0xFFFFFF88.
  - LBU @0x13 returns 0x00000088.
- SH 0x8001 @0x22, then LH @0x22 and LHU @0x22.
  - LH returns 0xFFFF8001; LHU returns 0x00008001.
  - Bytes @0x20–0x21 are unchanged.
- Error cases:
  - LW @0x06, SH @0x03, LW @0x100 (DEPTH = 64), funct3 = 011: each gives rsp_error = 1 and rsp_rdata = 0.
  - A subsequent LW of the targeted word shows no modification.
- Back-to-back traffic:
  - SW 0xDEADBEEF @0x40 followed immediately by LW @0x40 with req_valid held high.
  - Two consecutive rsp_valid pulses; the second carries 0xDEADBEEF.
- Reset asserted while a load is in flight.
  - No rsp_valid follows.
  - req_ready = 0 for DEPTH cycles.
  - Earlier data reads as 0 after init_done.

Source files
------------

// File: rtl/data_memory_bytewise_pkg.sv
// Shared types for the byte-addressable data memory: RV32 funct3 codes, FSM states, legality check.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents: load_f3_e / store_f3_e funct3 codes, state_e {CLEAR, READY},
// access-size codes taken from funct3[1:0], and is_legal(write, funct3).
package dmem_pkg;

  // Loads and stores reuse the same numeric codes, so they live in separate enums.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // funct3[1:0] encodes the access size for every legal code.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic logic is_legal(input logic write, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (funct3)
        SB, SH, SW: ok = 1'b1;
        default:    ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        LB, LH, LW, LBU, LHU: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_memory_bytewise_if.sv
// Request/response bundle between the load/store unit and the data memory.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; the response side has no backpressure.
//
// master: requester (drives req_*); slave: memory (drives req_ready, rsp_*, init_done).
interface data_memory_bytewise_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, init_done
  );
endinterface

// File: rtl/data_memory_bytewise_lane_align.sv
// Byte-lane steering for RV32 sub-word accesses: store enables/data, load extraction/extension.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports: funct3, lane (addr[1:0]), wdata_in, rword (stored word) ->
//        byte_en, wdata_out (lane-aligned), rdata_out (extended), misaligned.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out,
  output logic        misaligned
);

  logic [1:0]  size;
  logic [31:0] shifted;

  assign size    = funct3[1:0];
  // Bring the addressed byte down to bit 0 for loads.
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    byte_en    = 4'b0000;
    wdata_out  = wdata_in << {lane, 3'b000};
    rdata_out  = '0;
    misaligned = 1'b0;
    case (size)
      SIZE_B: begin
        byte_en   = 4'b0001 << lane;
        rdata_out = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        byte_en    = 4'b0011 << lane;
        misaligned = lane[0];
        rdata_out  = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        byte_en    = 4'b1111;
        misaligned = (lane != 2'b00);
        rdata_out  = rword;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_bytewise.sv
// Byte-addressable RV32 data memory with sub-word loads/stores and a post-reset clearing pass.
// Latency: 1 cycle for every accepted request (store commits on the accepting edge, load data registered).
// Backpressure: req_ready is low while clearing (DEPTH cycles after reset), then always high.
//
// Ports: clock, reset (sync, active-high), bus (slave modport: req_valid/ready/write/addr/
//        funct3/wdata in, rsp_valid/rdata/error and init_done out).
module data_memory_bytewise
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  data_memory_bytewise_if.slave bus
);

  localparam int IDXW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IDXW-1:0]   clr_idx_q, clr_idx_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic              accept;
  logic [IDXW-1:0]   widx;
  logic [31:0]       rword;
  logic              out_of_range;
  logic              req_err;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lane;
  logic [31:0]       load_data;
  logic              misaligned;

  logic              mem_we;
  logic [IDXW-1:0]   mem_widx;
  logic [31:0]       mem_wdata;

  assign bus.req_ready = (state_q == READY);
  assign bus.init_done = (state_q == READY);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign widx   = bus.req_addr[IDXW+1:2];
  // Any address bit above the array span means the access falls off the end.
  assign out_of_range = (bus.req_addr >> (IDXW + 2)) != '0;
  // Truncated index stays in range even for rejected addresses, so the read is always safe.
  assign rword  = mem[widx];
  assign req_err = !is_legal(bus.req_write, bus.req_funct3) || misaligned || out_of_range;

  dmem_lane_align u_align (
    .funct3     (bus.req_funct3),
    .lane       (bus.req_addr[1:0]),
    .wdata_in   (bus.req_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_out  (wdata_lane),
    .rdata_out  (load_data),
    .misaligned (misaligned)
  );

  // Single write port shared by the clearing pass and stores; a store merges
  // new lanes into the current word so unselected bytes keep their value.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = widx;
    mem_wdata = rword;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = clr_idx_q;
      mem_wdata = '0;
    end else if (accept && bus.req_write && !req_err) begin
      mem_we = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_wdata[8*b +: 8] = wdata_lane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Next-state and response computation.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rsp_valid_d = accept;
    rsp_error_d = accept && req_err;
    rsp_rdata_d = '0;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDXW'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    if (accept && !req_err && !bus.req_write) begin
      rsp_rdata_d = load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
